// File: rtl/mcpu_ctrl.sv
// Multi-cycle RV32I-subset control FSM: sequences IF/ID/EX/MEM/WB, stalls on MIO_ready,
// traps on illegal opcodes or memory timeout. Optional LUI/JALR states under MCPU_EXT_OPS_EN.
module mcpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemRW,
  output logic       CPU_MIO,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [2:0] ALU_Control,
  output logic [2:0] ImmSel,
  output logic [1:0] PCSource,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [3:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_I    = 5'b00100;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b01000;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
`ifdef MCPU_EXT_OPS_EN
  localparam logic [4:0] OP_LUI  = 5'b01101;
  localparam logic [4:0] OP_JALR = 5'b11001;
`endif
  localparam bit             TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXI = 4'd3,
    S_ADR = 4'd4, S_MRD = 4'd5, S_LWB = 4'd6, S_MWR = 4'd7,
    S_AWB = 4'd8, S_BR = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11
`ifdef MCPU_EXT_OPS_EN
    , S_LUI = 4'd12, S_JALR = 4'd13
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            trap_q;
  logic [1:0]      cause_q, cause_d;
  logic            wait_st, to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= (state_d == S_TRAP);
      cause_q <= cause_d;
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign wait_st    = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  assign to_hit     = TO_EN && !MIO_ready && (cnt_q == TO_LAST);

  // Wait counter runs only while parked in a memory state without ready.
  always_comb begin
    cnt_d = '0;
    if (wait_st && (state_d == state_q) && !MIO_ready)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
  end

  // Next state and control outputs; reset cycle forces all outputs to defaults.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemRW       = 1'b0;
    CPU_MIO     = 1'b0;
    ALUSrc_A    = 2'b00;
    ALUSrc_B    = 2'b00;
    ALU_Control = 3'b010;
    ImmSel      = 3'b000;
    PCSource    = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          MemRead  = 1'b1;
          CPU_MIO  = 1'b1;
          ALUSrc_B = 2'b10;
          if (MIO_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_ID;
          end else if (to_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end
        end
        S_ID: begin
          ALUSrc_A = 2'b10;
          ALUSrc_B = 2'b01;
          ImmSel   = (OPcode == OP_JAL) ? 3'b011 : 3'b010;
          case (OPcode)
            OP_R:          state_d = S_EXR;
            OP_I:          state_d = S_EXI;
            OP_LD, OP_ST:  state_d = S_ADR;
            OP_BR:         state_d = S_BR;
            OP_JAL:        state_d = S_JAL;
`ifdef MCPU_EXT_OPS_EN
            OP_LUI:        state_d = S_LUI;
            OP_JALR:       state_d = S_JALR;
`endif
            default: begin state_d = S_TRAP; cause_d = 2'b01; end
          endcase
        end
        S_EXR: begin
          ALUSrc_A = 2'b01;
          state_d  = S_AWB;
          case ({Fun3, Fun7})
            4'b0000: ALU_Control = 3'b010;
            4'b0001: ALU_Control = 3'b110;
            4'b0100: ALU_Control = 3'b111;
            4'b1000: ALU_Control = 3'b011;
            4'b1010: ALU_Control = 3'b101;
            4'b1100: ALU_Control = 3'b001;
            4'b1110: ALU_Control = 3'b000;
            default: begin state_d = S_TRAP; cause_d = 2'b01; end
          endcase
        end
        S_EXI: begin
          ALUSrc_A = 2'b01;
          ALUSrc_B = 2'b01;
          state_d  = S_AWB;
          case (Fun3)
            3'b000:  ALU_Control = 3'b010;
            3'b010:  ALU_Control = 3'b111;
            3'b100:  ALU_Control = 3'b011;
            3'b101:  ALU_Control = 3'b101;
            3'b110:  ALU_Control = 3'b001;
            3'b111:  ALU_Control = 3'b000;
            default: begin state_d = S_TRAP; cause_d = 2'b01; end
          endcase
        end
        S_ADR: begin
          ALUSrc_A = 2'b01;
          ALUSrc_B = 2'b01;
          ImmSel   = (OPcode == OP_LD) ? 3'b000 : 3'b001;
          state_d  = (OPcode == OP_LD) ? S_MRD : S_MWR;
        end
        S_MRD, S_MWR: begin
          IorD    = 1'b1;
          CPU_MIO = 1'b1;
          MemRead = (state_q == S_MRD);
          MemRW   = (state_q == S_MWR);
          if (MIO_ready) begin
            state_d = (state_q == S_MRD) ? S_LWB : S_IF;
          end else if (to_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end
        end
        S_LWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
          state_d  = S_IF;
        end
        S_AWB: begin
          RegWrite = 1'b1;
          state_d  = S_IF;
        end
        S_BR: begin
          ALUSrc_A    = 2'b01;
          ALU_Control = 3'b110;
          PCSource    = 2'b01;
          state_d     = S_IF;
          case (Fun3)
            3'b000:  PCWrite = zero;
            3'b001:  PCWrite = ~zero;
            default: begin state_d = S_TRAP; cause_d = 2'b01; end
          endcase
        end
        S_JAL: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b10;
          PCWrite  = 1'b1;
          PCSource = 2'b01;
          state_d  = S_IF;
        end
`ifdef MCPU_EXT_OPS_EN
        S_LUI: begin
          ImmSel   = 3'b100;
          MemtoReg = 2'b11;
          RegWrite = 1'b1;
          state_d  = S_IF;
        end
        S_JALR: begin
          ALUSrc_A = 2'b01;
          ALUSrc_B = 2'b01;
          PCWrite  = 1'b1;
          RegWrite = 1'b1;
          MemtoReg = 2'b10;
          state_d  = S_IF;
        end
`endif
        S_TRAP: state_d = S_TRAP;
        default: begin state_d = S_TRAP; cause_d = 2'b01; end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed scoreboard bench for mcpu_ctrl (MEM_TIMEOUT=4); honours MCPU_EXT_OPS_EN.
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] OPcode = '0;
  logic [2:0] Fun3 = '0;
  logic       Fun7 = 1'b0;
  logic       zero = 1'b0;
  logic       MIO_ready = 1'b0;
  logic       PCWrite, IRWrite, IorD, MemRead, MemRW, CPU_MIO, RegWrite, trap;
  logic [1:0] ALUSrc_A, ALUSrc_B, PCSource, MemtoReg, trap_cause;
  logic [2:0] ALU_Control, ImmSel;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  logic [27:0] sb[$];

  mcpu_ctrl #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7), .zero(zero),
    .MIO_ready(MIO_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemRW(MemRW), .CPU_MIO(CPU_MIO), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .ImmSel(ImmSel),
    .PCSource(PCSource), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .state(state),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pk(input logic [3:0] st, input logic pcw, irw, iord, mrd,
                                     mrw, mio, input logic [1:0] sa, sb_, input logic [2:0] alu,
                                     imm, input logic [1:0] pcs, m2r, input logic rw, tr,
                                     input logic [1:0] tc);
    return {st, pcw, irw, iord, mrd, mrw, mio, sa, sb_, alu, imm, pcs, m2r, rw, tr, tc};
  endfunction

  function automatic logic [27:0] e_rst();
    return pk(4'd0, 0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 3'b000, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_if(input logic r);
    return pk(4'd0, r,r,0,1,0,1, 2'b00, 2'b10, 3'b010, 3'b000, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_id(input logic [2:0] imm);
    return pk(4'd1, 0,0,0,0,0,0, 2'b10, 2'b01, 3'b010, imm, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_exr(input logic [2:0] alu);
    return pk(4'd2, 0,0,0,0,0,0, 2'b01, 2'b00, alu, 3'b000, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_awb();
    return pk(4'd8, 0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 3'b000, 2'b00, 2'b00, 1, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_adr(input logic [2:0] imm);
    return pk(4'd4, 0,0,0,0,0,0, 2'b01, 2'b01, 3'b010, imm, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_mrd();
    return pk(4'd5, 0,0,1,1,0,1, 2'b00, 2'b00, 3'b010, 3'b000, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_lwb();
    return pk(4'd6, 0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 3'b000, 2'b00, 2'b01, 1, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_br(input logic pcw);
    return pk(4'd9, pcw,0,0,0,0,0, 2'b01, 2'b00, 3'b110, 3'b000, 2'b01, 2'b00, 0, 0, 2'b00);
  endfunction
  function automatic logic [27:0] e_trap(input logic [1:0] c);
    return pk(4'd11, 0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 3'b000, 2'b00, 2'b00, 0, 1, c);
  endfunction
  function automatic logic [27:0] e_lui();
    return pk(4'd12, 0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 3'b100, 2'b00, 2'b11, 1, 0, 2'b00);
  endfunction

  // Drive one cycle's inputs at negedge, compare settled outputs against the queue head.
  task automatic cyc(input string tag, input logic [4:0] op, input logic [2:0] f3,
                     input logic f7, input logic rdy, input logic z);
    logic [27:0] obs, exp;
    OPcode = op; Fun3 = f3; Fun7 = f7; MIO_ready = rdy; zero = z;
    #1;
    obs = pk(state, PCWrite, IRWrite, IorD, MemRead, MemRW, CPU_MIO, ALUSrc_A, ALUSrc_B,
             ALU_Control, ImmSel, PCSource, MemtoReg, RegWrite, trap, trap_cause);
    exp = sb.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    sb.push_back(e_rst()); cyc("reset", 5'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // add x3,x1,x2
    sb.push_back(e_if(1));        cyc("add_if",  5'b01100, 3'b000, 0, 1, 0);
    sb.push_back(e_id(3'b010));   cyc("add_id",  5'b01100, 3'b000, 0, 0, 0);
    sb.push_back(e_exr(3'b010));  cyc("add_exr", 5'b01100, 3'b000, 0, 0, 0);
    sb.push_back(e_awb());        cyc("add_awb", 5'b01100, 3'b000, 0, 0, 0);

    // lw with three wait cycles in MRD
    sb.push_back(e_if(1));        cyc("lw_if",   5'b00000, 3'b010, 0, 1, 0);
    sb.push_back(e_id(3'b010));   cyc("lw_id",   5'b00000, 3'b010, 0, 0, 0);
    sb.push_back(e_adr(3'b000));  cyc("lw_adr",  5'b00000, 3'b010, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(e_mrd());      cyc("lw_mrd_wait", 5'b00000, 3'b010, 0, 0, 0);
    end
    sb.push_back(e_mrd());        cyc("lw_mrd_rdy", 5'b00000, 3'b010, 0, 1, 0);
    sb.push_back(e_lwb());        cyc("lw_lwb",  5'b00000, 3'b010, 0, 0, 0);

    // beq then bne, both with zero=1
    sb.push_back(e_if(1));        cyc("beq_if",  5'b11000, 3'b000, 0, 1, 1);
    sb.push_back(e_id(3'b010));   cyc("beq_id",  5'b11000, 3'b000, 0, 0, 1);
    sb.push_back(e_br(1));        cyc("beq_br",  5'b11000, 3'b000, 0, 0, 1);
    sb.push_back(e_if(1));        cyc("bne_if",  5'b11000, 3'b001, 0, 1, 1);
    sb.push_back(e_id(3'b010));   cyc("bne_id",  5'b11000, 3'b001, 0, 0, 1);
    sb.push_back(e_br(0));        cyc("bne_br",  5'b11000, 3'b001, 0, 0, 1);

    // sub, then illegal Fun3=001/Fun7=1
    sb.push_back(e_if(1));        cyc("sub_if",  5'b01100, 3'b000, 1, 1, 0);
    sb.push_back(e_id(3'b010));   cyc("sub_id",  5'b01100, 3'b000, 1, 0, 0);
    sb.push_back(e_exr(3'b110));  cyc("sub_exr", 5'b01100, 3'b000, 1, 0, 0);
    sb.push_back(e_awb());        cyc("sub_awb", 5'b01100, 3'b000, 1, 0, 0);
    sb.push_back(e_if(1));        cyc("bad_if",  5'b01100, 3'b001, 1, 1, 0);
    sb.push_back(e_id(3'b010));   cyc("bad_id",  5'b01100, 3'b001, 1, 0, 0);
    sb.push_back(e_exr(3'b010));  cyc("bad_exr", 5'b01100, 3'b001, 1, 0, 0);
    sb.push_back(e_trap(2'b01));  cyc("bad_trap", 5'b01100, 3'b001, 1, 1, 0);
    sb.push_back(e_trap(2'b01));  cyc("bad_trap_hold", 5'b01100, 3'b001, 1, 1, 0);
    do_reset();

    // illegal opcode 11111
    sb.push_back(e_if(1));        cyc("ill_if",  5'b11111, 3'b000, 0, 1, 0);
    sb.push_back(e_id(3'b010));   cyc("ill_id",  5'b11111, 3'b000, 0, 0, 0);
    sb.push_back(e_trap(2'b01));  cyc("ill_trap", 5'b11111, 3'b000, 0, 0, 0);
    do_reset();

    // LUI opcode: legal only with the extension enabled
    sb.push_back(e_if(1));        cyc("lui_if",  5'b01101, 3'b000, 0, 1, 0);
    sb.push_back(e_id(3'b010));   cyc("lui_id",  5'b01101, 3'b000, 0, 0, 0);
`ifdef MCPU_EXT_OPS_EN
    sb.push_back(e_lui());        cyc("lui_wb",  5'b01101, 3'b000, 0, 0, 0);
    sb.push_back(e_if(0));        cyc("lui_next_if", 5'b01101, 3'b000, 0, 0, 0);
`else
    sb.push_back(e_trap(2'b01));  cyc("lui_trap", 5'b01101, 3'b000, 0, 0, 0);
`endif
    do_reset();

    // fetch timeout: four cycles without ready, then trap cause 10
    for (int i = 0; i < 4; i++) begin
      sb.push_back(e_if(0));      cyc("to_if_wait", 5'b00000, 3'b000, 0, 0, 0);
    end
    sb.push_back(e_trap(2'b10));  cyc("to_trap", 5'b00000, 3'b000, 0, 0, 0);
    sb.push_back(e_trap(2'b10));  cyc("to_trap_hold", 5'b00000, 3'b000, 0, 1, 0);
    do_reset();
    sb.push_back(e_if(0));        cyc("post_rst_if", 5'b00000, 3'b000, 0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
